// File: rtl/pwm_meas.sv
// PWM period / high-time measurement: synchronizes an asynchronous PWM input,
// times successive rising edges and hands results to a consumer with valid/ready.
module pwm_meas #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             ready,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             overrun,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   s_d_q, s_d_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_tmp_q, hi_tmp_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       high_time_q, high_time_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  logic s;
  logic primed;
  logic rise;
  logic fall;
  logic cnt_sat;
  logic new_meas;

  // fill_q tracks which synchronizer stages hold a real sample since reset, so
  // the reset zeros are never mistaken for a low level of pwm_in.
  assign s       = sync_q[SYNC_STAGES-1];
  assign primed  = fill_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign cnt_sat = (cnt_q == CNT_MAX);

  // Synchronizer shift, edge-detect delay and saturating cycle counter
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
    s_d_d  = s;
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (cnt_sat) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Measurement FSM next state, result capture and handshake
  always_comb begin
    state_d     = state_q;
    hi_tmp_d    = hi_tmp_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    timeout_d   = 1'b0;
    new_meas    = 1'b0;

    case (state_q)
      WAIT_LOW: begin
        if (primed && !s) begin
          state_d = WAIT_RISE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = HIGH;
        end else begin
          state_d = WAIT_RISE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d  = LOW;
          hi_tmp_d = cnt_q;
        end else if (cnt_sat) begin
          state_d   = WAIT_LOW;
          timeout_d = 1'b1;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (rise) begin
          state_d  = HIGH;
          new_meas = 1'b1;
        end else if (cnt_sat) begin
          state_d   = WAIT_LOW;
          timeout_d = 1'b1;
        end else begin
          state_d = LOW;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase

    // A completing measurement wins over a same-cycle handshake.
    if (new_meas) begin
      period_d    = cnt_q;
      high_time_d = hi_tmp_q;
      valid_d     = 1'b1;
      overrun_d   = valid_q & ~ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOW;
      sync_q      <= {SYNC_STAGES{1'b0}};
      fill_q      <= {SYNC_STAGES{1'b0}};
      s_d_q       <= 1'b0;
      cnt_q       <= {WIDTH{1'b0}};
      hi_tmp_q    <= {WIDTH{1'b0}};
      period_q    <= {WIDTH{1'b0}};
      high_time_q <= {WIDTH{1'b0}};
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      s_d_q       <= s_d_d;
      cnt_q       <= cnt_d;
      hi_tmp_q    <= hi_tmp_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;
  assign level     = s;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed + randomized bench for pwm_meas: a 16-bit and an 8-bit instance share
// stimulus and are compared every cycle against an edge-timestamp reference model.
module tb_pwm_meas;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic pwm_in = 1'b0;
  logic ready = 1'b0;

  logic [15:0] per16, ht16;
  logic        v16, o16, t16, l16;
  logic [7:0]  per8, ht8;
  logic        v8, o8, t8, l8;

  pwm_meas #(.WIDTH(16), .SYNC_STAGES(SYNC)) u_dut16 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .ready(ready),
    .period(per16), .high_time(ht16), .valid(v16),
    .overrun(o16), .timeout(t16), .level(l16)
  );

  pwm_meas #(.WIDTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .ready(ready),
    .period(per8), .high_time(ht8), .valid(v8),
    .overrun(o8), .timeout(t8), .level(l8)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: timestamps of synchronized edges, index 0 = 16-bit, 1 = 8-bit.
  int mx [2] = '{65535, 255};
  bit need_low [2];
  bit armed [2];
  int rise_e [2];
  int hi_len [2];
  int m_per [2];
  int m_ht [2];
  bit m_valid [2];
  bit m_ovr [2];
  bit m_tout [2];
  bit [SYNC-1:0] m_sync = '0;
  bit m_sd = 1'b0;
  int k = 0;
  int n_since = 0;

  // Window statistics for directed scenario checks
  int step_no = 0;
  int win_p, win_h, win_v, win_m, win_o, win_t8, win_t16, win_v8, win_m8;
  int first_p, first_h, t8_at;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit s_now, rise, fall, newm;
    k++;
    if (rst) begin
      m_sync  = '0;
      m_sd    = 1'b0;
      n_since = 0;
      for (int i = 0; i < 2; i++) begin
        need_low[i] = 1'b1; armed[i] = 1'b0;
        m_per[i] = 0; m_ht[i] = 0;
        m_valid[i] = 1'b0; m_ovr[i] = 1'b0; m_tout[i] = 1'b0;
      end
    end else begin
      s_now = m_sync[SYNC-1];
      rise  = s_now & !m_sd;
      fall  = !s_now & m_sd;
      for (int i = 0; i < 2; i++) begin
        newm = 1'b0;
        m_ovr[i] = 1'b0;
        m_tout[i] = 1'b0;
        if (need_low[i]) begin
          if (n_since >= SYNC && !s_now) need_low[i] = 1'b0;
        end else if (!armed[i]) begin
          if (rise) begin armed[i] = 1'b1; rise_e[i] = k; end
        end else if (rise) begin
          newm = 1'b1;
          m_ovr[i] = m_valid[i] && !ready;
          m_valid[i] = 1'b1;
          m_per[i] = min_i(k - rise_e[i], mx[i]);
          m_ht[i] = hi_len[i];
          rise_e[i] = k;
        end else if (fall) begin
          hi_len[i] = min_i(k - rise_e[i], mx[i]);
        end else if (k - rise_e[i] >= mx[i]) begin
          m_tout[i] = 1'b1;
          need_low[i] = 1'b1;
          armed[i] = 1'b0;
        end
        if (!newm && m_valid[i] && ready) m_valid[i] = 1'b0;
      end
      m_sd = s_now;
      m_sync = {m_sync[SYNC-2:0], pwm_in};
      n_since++;
    end
  endtask

  task automatic check_cycle();
    chk("period16", per16, m_per[0]);
    chk("high16", ht16, m_ht[0]);
    chk("valid16", v16, m_valid[0]);
    chk("overrun16", o16, m_ovr[0]);
    chk("timeout16", t16, m_tout[0]);
    chk("level16", l16, m_sync[SYNC-1]);
    chk("period8", per8, m_per[1]);
    chk("high8", ht8, m_ht[1]);
    chk("valid8", v8, m_valid[1]);
    chk("overrun8", o8, m_ovr[1]);
    chk("timeout8", t8, m_tout[1]);
    chk("level8", l8, m_sync[SYNC-1]);
    if (v16) begin
      win_v++;
      if (per16 == win_p[15:0] && ht16 == win_h[15:0]) win_m++;
      if (first_p < 0) begin first_p = per16; first_h = ht16; end
    end
    if (v8) begin
      win_v8++;
      if (per8 == win_p[7:0] && ht8 == win_h[7:0]) win_m8++;
    end
    if (o16) win_o++;
    if (t16) win_t16++;
    if (t8) begin
      win_t8++;
      if (t8_at < 0) t8_at = step_no;
    end
  endtask

  task automatic step(input logic p, input logic r, input logic rd);
    pwm_in = p;
    rst    = r;
    ready  = rd;
    @(posedge clk);
    model_edge();
    #1;
    step_no++;
    check_cycle();
  endtask

  task automatic hold(input logic lvl, input int n, input logic rd);
    for (int i = 0; i < n; i++) step(lvl, 1'b0, rd);
  endtask

  task automatic pwm_periods(input int n, input int p, input int h, input logic rd);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, h, rd);
      hold(1'b0, p - h, rd);
    end
  endtask

  task automatic win_open(input int p, input int h);
    win_p = p; win_h = h;
    win_v = 0; win_m = 0; win_o = 0; win_t8 = 0; win_t16 = 0;
    win_v8 = 0; win_m8 = 0; first_p = -1; first_h = -1; t8_at = -1;
  endtask

  initial begin
    int start, p, h;
    win_open(0, 0);

    // Reset state
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_period", per16, 0);
    chk("rst_valid", v16, 0);
    chk("rst_level", l16, 0);

    // Repeated 10/3 with ready=1
    hold(1'b0, 5, 1'b1);
    win_open(10, 3);
    pwm_periods(6, 10, 3, 1'b1);
    chk("p10_count", win_v, 5);
    chk("p10_match", win_m, 5);
    chk("p10_overrun", win_o, 0);

    // Minimum period 2/1
    step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 4, 1'b1);
    win_open(2, 1);
    pwm_periods(10, 2, 1, 1'b1);
    hold(1'b0, 4, 1'b1);
    chk("p2_count", win_v, 9);
    chk("p2_match", win_m, 9);

    // pwm_in high across reset release: partial pulse never reported
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 4, 1'b1);
    hold(1'b0, 3, 1'b1);
    win_open(8, 5);
    pwm_periods(3, 8, 5, 1'b1);
    hold(1'b0, 4, 1'b1);
    chk("p8_count", win_v, 2);
    chk("p8_first_period", first_p, 8);
    chk("p8_first_high", first_h, 5);

    // Overrun: two results without ready
    step(1'b0, 1'b1, 1'b0);
    hold(1'b0, 4, 1'b0);
    win_open(12, 6);
    hold(1'b1, 4, 1'b0); hold(1'b0, 8, 1'b0);
    hold(1'b1, 6, 1'b0); hold(1'b0, 6, 1'b0);
    hold(1'b1, 2, 1'b0); hold(1'b0, 10, 1'b0);
    chk("ovr_count", win_o, 1);
    chk("ovr_valid", v16, 1);
    chk("ovr_period", per16, 12);
    chk("ovr_high", ht16, 6);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr_consumed", v16, 0);
    chk("ovr_hold_period", per16, 12);

    // Timeout on the 8-bit instance: pwm held high after a 20/7 period
    hold(1'b0, 3, 1'b1);
    hold(1'b1, 7, 1'b1); hold(1'b0, 13, 1'b1);
    win_open(20, 7);
    start = step_no;
    hold(1'b1, 300, 1'b1);
    chk("to_count8", win_t8, 1);
    chk("to_count16", win_t16, 0);
    chk("to_cycle8", t8_at - start, SYNC + 256);
    chk("to_level8", l8, 1);
    chk("to_keep_period8", per8, 20);
    chk("to_keep_high8", ht8, 7);
    hold(1'b0, 5, 1'b1);
    win_open(10, 3);
    pwm_periods(3, 10, 3, 1'b1);
    chk("to_rearm_count8", win_v8, 2);
    chk("to_rearm_match8", win_m8, 2);

    // Reset in the middle of a high phase
    hold(1'b1, 2, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_rst_period16", per16, 0);
    chk("mid_rst_high8", ht8, 0);
    chk("mid_rst_valid8", v8, 0);
    hold(1'b1, 1, 1'b1);
    hold(1'b0, 7, 1'b1);
    win_open(10, 3);
    pwm_periods(3, 10, 3, 1'b1);
    hold(1'b0, 4, 1'b1);
    chk("mid_rst_count", win_v, 2);
    chk("mid_rst_first", first_p, 10);

    // Random periods and random ready, checked by the model every cycle
    step(1'b0, 1'b1, 1'b1);
    hold(1'b0, 4, 1'b1);
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(60, 2);
      h = $urandom_range(p - 1, 1);
      for (int j = 0; j < p; j++) step((j < h) ? 1'b1 : 1'b0, 1'b0, 1'($urandom_range(1, 0)));
    end
    hold(1'b0, 6, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_meas.md
PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 Parameter WIDTH, default 16, sets the width of the counter and of the measurement results.
REQ-002 Parameter SYNC_STAGES, default 2 (minimum 2), sets the number of input synchronizer flops.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port pwm_in, input, 1 bit: asynchronous PWM waveform, typically a PWM generator's out.
REQ-006 Port period, output, WIDTH bits: last measured period in clk cycles.
REQ-007 Port high_time, output, WIDTH bits: high-phase length of that same period, in clk cycles.
REQ-008 Port valid, output, 1 bit: period/high_time hold an unconsumed measurement.
REQ-009 Port ready, input, 1 bit: consumer accepts the measurement when valid&ready.
REQ-010 Port overrun, output, 1 bit: one-cycle pulse when an unconsumed measurement is overwritten.
REQ-011 Port timeout, output, 1 bit: one-cycle pulse when no edge occurs within 2^WIDTH-1 cycles.
REQ-012 Port level, output, 1 bit: synchronized pwm_in (last synchronizer stage).

Function
REQ-013 pwm_in SHALL pass through a SYNC_STAGES-flop synchronizer; s = last stage; s_d = s delayed one cycle.
REQ-014 rise = s & ~s_d; fall = ~s & s_d; only s, rise and fall SHALL drive the measurement logic.
REQ-015 Counter cnt SHALL load 1 on a rise cycle, else increment, saturating at 2^WIDTH-1.
REQ-016 States SHALL be WAIT_LOW, WAIT_RISE, HIGH, LOW.
REQ-017 WAIT_LOW -> WAIT_RISE when s==0, which rejects a partial high pulse present at reset release.
REQ-018 WAIT_RISE -> HIGH on rise.
REQ-019 HIGH -> LOW on fall, latching hi_tmp <= cnt.
REQ-020 LOW -> HIGH on rise, registering period <= cnt, high_time <= hi_tmp, valid <= 1.
REQ-021 Measured values SHALL satisfy: a PWM with P-cycle period and H-cycle high phase yields period=P, high_time=H.
REQ-022 period/high_time/valid SHALL update the cycle after the rise detection cycle.
REQ-023 Total pwm_in-to-valid latency SHALL be SYNC_STAGES+1 cycles after the rising edge ending a period.
REQ-024 In HIGH or LOW, if cnt==2^WIDTH-1 and no edge occurs that cycle, the block SHALL pulse timeout for one cycle and go to WAIT_LOW.
REQ-025 The timeout (REQ-024) SHALL NOT modify period, high_time or valid.
REQ-026 An edge in the same cycle as saturation SHALL take priority over the timeout.
REQ-027 Handshake: valid&ready in a cycle with no new measurement SHALL clear valid next cycle.
REQ-028 period/high_time SHALL remain stable while valid=1 and no new measurement completes.
REQ-029 If a new measurement completes while valid=1 and ready=0, the block SHALL overwrite the results, keep valid=1 and pulse overrun.
REQ-030 If a new measurement completes in the same cycle as valid&ready, the block SHALL load the new results, keep valid=1 and NOT pulse overrun.
REQ-031 Values 0% and 100% duty cause no edges and SHALL be reported only through timeout; level gives the static state.
REQ-032 The minimum measurable period SHALL be 2 (high 1, low 1); glitches shorter than one clk are not guaranteed to be seen.

Reset
REQ-033 On rst=1 at posedge, state SHALL be WAIT_LOW.
REQ-034 On reset, synchronizer flops, s_d, cnt, hi_tmp, period, high_time, valid, overrun and timeout SHALL all be 0.
REQ-035 Reset mid-measurement SHALL discard the partial period; the first valid after reset requires a low, a full high phase and the next rise.
REQ-036 rst SHALL override all other inputs in the same cycle.

Verification
REQ-037 Bench (WIDTH=16, SYNC_STAGES=2) SHALL cover: repeated PWM of 10 cycles high 3, ready=1 -> from the second rise, each period yields period=10, high_time=3, valid for 1 cycle.
REQ-038 Bench SHALL cover: pwm_in high at reset release, then PWM period 8 high 5 -> first valid result is 8/5; the partial initial pulse is never reported.
REQ-039 Bench SHALL cover: ready=0 across two completed periods (12/4, then 12/6) -> overrun pulses once; outputs hold 12/6 with valid=1; one ready cycle clears valid.
REQ-040 Bench (WIDTH=8) SHALL cover: pwm_in held high after a rise -> timeout pulses exactly when cnt reaches 255, state returns to WAIT_LOW, level=1, and the prior results are unchanged.
REQ-041 Bench SHALL cover: rst asserted for 1 cycle in the middle of a high phase -> all outputs 0 next cycle; the next valid appears only after a full subsequent period, with correct values.
REQ-042 Bench SHALL cover: period 2, high 1 -> period=2, high_time=1 on every period.
